// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-master DataMemory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic midx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a pointer that toggles on each completed access.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output midx_t      gnt,
    output logic       valid
);

    logic ptr;

    // The pointer only breaks ties; a lone requester always wins.
    always_comb begin
        valid = |req;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ptr;
            default: gnt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (update) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer placing two masters in front of the big-endian DataMemory.
// Optional alignment check with err outputs: define DMEM_ALIGN_CHECK_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic              m0_err,
    output logic              m1_err,
`endif
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_data
);

    localparam int unsigned      CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

    state_t            state;
    midx_t             gnt_idx;
    midx_t             win;
    logic              win_valid;
    logic              lat_we;
    logic [CNT_W-1:0]  cnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_adr;
    logic [DATA_W-1:0] sel_wdata;
`ifdef DMEM_ALIGN_CHECK_EN
    logic              lat_err;
    logic              unaligned;
`endif

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    ({m1_req, m0_req}),
        .update (state == DONE),
        .gnt    (win),
        .valid  (win_valid)
    );

    assign sel_we    = win ? m1_we    : m0_we;
    assign sel_adr   = win ? m1_adr   : m0_adr;
    assign sel_wdata = win ? m1_wdata : m0_wdata;
`ifdef DMEM_ALIGN_CHECK_EN
    assign unaligned = |sel_adr[1:0];
`endif

    // mem_adr/mem_writedata are the latch registers themselves, so live master inputs never reach memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            gnt_idx       <= 1'b0;
            lat_we        <= 1'b0;
            cnt           <= '0;
            mem_adr       <= '0;
            mem_writedata <= '0;
            m0_rdata      <= '0;
            m1_rdata      <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
            lat_err       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        gnt_idx       <= win;
                        lat_we        <= sel_we;
                        mem_adr       <= sel_adr;
                        mem_writedata <= sel_wdata;
                        cnt           <= CNT_INIT;
`ifdef DMEM_ALIGN_CHECK_EN
                        lat_err       <= unaligned;
                        state         <= unaligned ? DONE : ACCESS;
`else
                        state         <= ACCESS;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (!lat_we) begin
                            if (gnt_idx) begin
                                m1_rdata <= mem_data;
                            end else begin
                                m0_rdata <= mem_data;
                            end
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are gated by reset so the memory's reset-time load sees no access.
    assign mem_memread  = !reset && (state == ACCESS) && !lat_we;
    assign mem_memwrite = !reset && (state == ACCESS) && lat_we && (cnt == '0);

    assign m0_ack = (state == DONE) && (gnt_idx == 1'b0);
    assign m1_ack = (state == DONE) && (gnt_idx == 1'b1);
`ifdef DMEM_ALIGN_CHECK_EN
    assign m0_err = m0_ack && lat_err;
    assign m1_err = m1_ack && lat_err;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-array DataMemory stand-in and a word-level reference model.
module tb_dmem_arbiter;

    localparam int unsigned W = 1;

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_a [2];
    logic        we_a  [2];
    logic [31:0] adr_a [2];
    logic [31:0] wd_a  [2];
    logic        ack0, ack1;
    logic [31:0] rd0, rd1;
    logic [31:0] mem_adr, mem_wdata, mem_data;
    logic        mem_rd, mem_wr;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        err0, err1;
`endif

    logic [7:0]  bmem [0:255] = '{default: 8'h00};
    logic [31:0] ref_mem [0:63] = '{default: 32'h0};
    logic [31:0] last_rd [2] = '{32'h0, 32'h0};
    int unsigned done_cnt = 0;

    exp_t        q0 [$];
    exp_t        q1 [$];
    int          ack_order [$];
    int unsigned ack_cyc [$];
    int unsigned cyc = 0;
    int unsigned rd_n = 0, wr_n = 0, wr_at = 0, wr_total = 0, ack_total = 0;
    int          total = 0, bad = 0;

    dmem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .m0_req        (req_a[0]),
        .m0_we         (we_a[0]),
        .m0_adr        (adr_a[0]),
        .m0_wdata      (wd_a[0]),
        .m0_ack        (ack0),
        .m0_rdata      (rd0),
        .m1_req        (req_a[1]),
        .m1_we         (we_a[1]),
        .m1_adr        (adr_a[1]),
        .m1_wdata      (wd_a[1]),
        .m1_ack        (ack1),
        .m1_rdata      (rd1),
`ifdef DMEM_ALIGN_CHECK_EN
        .m0_err        (err0),
        .m1_err        (err1),
`endif
        .mem_adr       (mem_adr),
        .mem_writedata (mem_wdata),
        .mem_memread   (mem_rd),
        .mem_memwrite  (mem_wr),
        .mem_data      (mem_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Big-endian byte memory: word at adr is bytes adr..adr+3, MSB first.
    always @(posedge clk) begin
        if (mem_wr) begin
            for (int k = 0; k < 4; k++)
                bmem[mem_adr[7:0] + 8'(k)] <= mem_wdata[31 - 8*k -: 8];
        end
    end
    always_comb mem_data = {bmem[mem_adr[7:0]], bmem[mem_adr[7:0] + 8'd1],
                            bmem[mem_adr[7:0] + 8'd2], bmem[mem_adr[7:0] + 8'd3]};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic on_ack(input int m);
        exp_t e;
        logic [31:0] rd;
        rd = (m == 0) ? rd0 : rd1;
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            chk($sformatf("unexpected_ack_m%0d", m), 32'd1, 32'd0);
        end else begin
            e = (m == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rdata_m%0d", m), rd, e.rdata);
            chk("strobe_in_done", {30'd0, mem_rd, mem_wr}, 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
            chk($sformatf("err_m%0d", m), (m == 0) ? err0 : err1, e.err);
`endif
            if (e.err) begin
                chk("rd_cycles_err", rd_n, 0);
                chk("wr_cycles_err", wr_n, 0);
            end else if (e.we) begin
                chk("rd_cycles_wr", rd_n, 0);
                chk("wr_cycles_wr", wr_n, 1);
            end else begin
                chk("rd_cycles_rd", rd_n, W + 1);
                chk("wr_cycles_rd", wr_n, 0);
            end
        end
        ack_order.push_back(m);
        ack_cyc.push_back(cyc);
        ack_total++;
        done_cnt++;
        rd_n = 0;
        wr_n = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_n = 0;
                wr_n = 0;
            end else begin
                if (mem_rd) rd_n++;
                if (mem_wr) begin
                    wr_n++;
                    wr_total++;
                    wr_at = cyc;
                end
                if (ack0 && ack1) chk("dual_ack", 32'd1, 32'd0);
                else if (ack0) on_ack(0);
                else if (ack1) on_ack(1);
            end
        end
    end

    // Issue one access: the reference model computes its response at issue time.
    task automatic access(input int m, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input bit hold, input int lat_exp);
        exp_t e;
        int unsigned t0;
        bit got;
        e.we  = we;
        e.err = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) e.err = 1'b1;
`endif
        if (e.err || we) begin
            e.rdata = last_rd[m];
            if (!e.err) ref_mem[a[7:2]] = d;
        end else begin
            last_rd[m] = ref_mem[a[7:2]];
            e.rdata    = last_rd[m];
        end
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
        req_a[m] = 1'b1;
        we_a[m]  = we;
        adr_a[m] = a;
        wd_a[m]  = d;
        t0  = cyc;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((m == 0) ? ack0 : ack1) begin
                got = 1'b1;
                break;
            end
            if (i == 1 && lat_exp >= 0) begin
                we_a[m]  = ~we_a[m];
                adr_a[m] = $urandom;
                wd_a[m]  = $urandom;
            end
        end
        if (!got) chk($sformatf("ack_timeout_m%0d", m), 32'd0, 32'd1);
        else if (lat_exp >= 0) chk($sformatf("latency_m%0d", m), cyc - t0, lat_exp);
        @(posedge clk);
        #1;
        if (!hold) req_a[m] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned tc, at, wt, base, first;
        logic [31:0] old;
        for (int m = 0; m < 2; m++) begin
            req_a[m] = 1'b0; we_a[m] = 1'b0; adr_a[m] = '0; wd_a[m] = '0;
        end
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ack0", ack0, 0);   chk("rst_ack1", ack1, 0);
        chk("rst_rd0", rd0, 0);     chk("rst_rd1", rd1, 0);
        chk("rst_madr", mem_adr, 0); chk("rst_mwd", mem_wdata, 0);
        chk("rst_strobes", {mem_rd, mem_wr}, 0);
        @(posedge clk); #1 reset = 1'b0;

        // m0 write then m1 read of the same word.
        @(posedge clk); #1;
        tc = cyc;
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, W + 2);
        chk("write_cycle", wr_at, tc + W + 1);
        chk("byte10", bmem[8'h10], 8'hDE); chk("byte11", bmem[8'h11], 8'hAD);
        chk("byte12", bmem[8'h12], 8'hBE); chk("byte13", bmem[8'h13], 8'hEF);
        at = ack_total;
        access(1, 1'b0, 32'h10, 32'h0, 1'b0, W + 2);
        chk("m1_read_data", rd1, 32'hDEADBEEF);
        chk("m1_read_one_ack", ack_total - at, 1);
        chk("m0_rdata_untouched", rd0, 32'h0);

        // Contention: both hold requests; grants must alternate, one access per W+3 cycles.
        base  = ack_order.size();
        first = done_cnt % 2;
        fork
            begin
                access(0, 1'b1, 32'h04, 32'h01020304, 1'b1, -1);
                access(0, 1'b0, 32'h04, 32'h0, 1'b0, -1);
            end
            begin
                access(1, 1'b1, 32'h44, 32'hA0B0C0D0, 1'b1, -1);
                access(1, 1'b0, 32'h44, 32'h0, 1'b0, -1);
            end
        join
        for (int k = 0; k < 4; k++) chk("rr_order", ack_order[base + k], (first + k) % 2);
        for (int k = 1; k < 4; k++) chk("rr_gap", ack_cyc[base + k] - ack_cyc[base + k - 1], W + 3);

        // Lone m1 back-to-back is never stalled, whichever way the pointer faces.
        for (int r = 0; r < 2; r++) begin
            base = ack_order.size();
            access(1, 1'b1, 32'h48, $urandom, 1'b1, W + 2);
            access(1, 1'b0, 32'h48, 32'h0, 1'b0, W + 2);
            chk("lone_gap", ack_cyc[base + 1] - ack_cyc[base], W + 3);
        end

        // Reset during the first ACCESS cycle of a write: nothing reaches memory, no ack.
        @(posedge clk); #1;
        wt = wr_total; at = ack_total; old = ref_mem[8];
        req_a[0] = 1'b1; we_a[0] = 1'b1; adr_a[0] = 32'h20; wd_a[0] = 32'h55AA55AA;
        @(posedge clk); #1;
        reset = 1'b1; req_a[0] = 1'b0;
        #1;
        chk("midrst_strobes", {mem_rd, mem_wr}, 0);
        chk("midrst_rd0", rd0, 0);
        chk("midrst_madr", mem_adr, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0; done_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_write", wr_total - wt, 0);
        chk("midrst_no_ack", ack_total - at, 0);
        chk("midrst_word", {bmem[8'h20], bmem[8'h21], bmem[8'h22], bmem[8'h23]}, old);
        access(1, 1'b0, 32'h20, 32'h0, 1'b0, W + 2);

`ifdef DMEM_ALIGN_CHECK_EN
        tc = wr_total;
        old = rd0;
        access(0, 1'b0, 32'h13, 32'h0, 1'b0, 1);
        chk("unaligned_rdata_kept", rd0, old);
        chk("unaligned_no_write", wr_total - tc, 0);
        access(0, 1'b0, 32'h10, 32'h0, 1'b0, W + 2);
`endif

        // Random concurrent traffic; each master owns its own address region.
        fork
            for (int k = 0; k < 25; k++) begin
                bit h;
                int g;
                h = (k != 24) && ($urandom % 2 == 1);
                access(0, 1'($urandom % 2), 32'(($urandom % 16) * 4), $urandom, h, -1);
                if (!h) begin
                    g = $urandom % 3;
                    if (g > 0) begin repeat (g) @(posedge clk); #1; end
                end
            end
            for (int k = 0; k < 25; k++) begin
                bit h;
                int g;
                h = (k != 24) && ($urandom % 2 == 1);
                access(1, 1'($urandom % 2), 32'h40 + 32'(($urandom % 16) * 4), $urandom, h, -1);
                if (!h) begin
                    g = $urandom % 3;
                    if (g > 0) begin repeat (g) @(posedge clk); #1; end
                end
            end
        join

        repeat (3) @(posedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        for (int i = 0; i < 64; i++)
            chk($sformatf("mem_word_%0d", i),
                {bmem[4*i], bmem[4*i + 1], bmem[4*i + 2], bmem[4*i + 3]}, ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
